mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported memory with variable latency.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin on simultaneous requests; default is data-priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_e;

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;
  logic                owner_q, owner_d;
  logic                grant_data_c;

  // owner_q doubles as the last-served port: it is updated at every grant.
`ifdef ARB_ROUND_ROBIN_EN
  assign grant_data_c = (d_req && i_req) ? ~owner_q : d_req;
`else
  assign grant_data_c = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
    end
  end

  // Next state, request latching and read-data capture; strobes decode from the next state.
  always_comb begin
    state_d     = state_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    owner_d     = owner_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d = ST_ISSUE;
          owner_d = grant_data_c;
          if (grant_data_c) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wr_d    = d_wr;
          end else begin
            mem_addr_d  = i_addr;
            mem_wr_d    = 1'b0;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_valid) begin
          state_d = ST_ACK;
          if (!mem_wr_q) begin
            if (owner_q) d_rdata_d = mem_rdata;
            else         i_rdata_d = mem_rdata;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mem_en_d = (state_d == ST_ISSUE);
    busy_d   = (state_d != ST_IDLE);
    i_ack_d  = (state_d == ST_ACK) && !owner_d;
    d_ack_d  = (state_d == ST_ACK) &&  owner_d;
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
